// File: rtl/spi_target.sv
// rtl/spi_target.sv - SPI mode-0 target exchanging bytes with software through TX/RX byte FIFOs
//
// spi_target_fifo: byte FIFO with first-word fall-through read data.
//   clk, rst          clock and synchronous active-high reset
//   wr_en, wr_data    push request and byte (ignored when full unless a pop happens the same clk)
//   rd_en             pop request (ignored when empty)
//   rd_data           current head byte
//   empty, full       occupancy flags
//
// spi_target: SPI mode-0 responder; all pins are oversampled in the clk domain.
//   clk, Rst                     mmio clock and synchronous active-high reset
//   spi_sck, spi_cs, spi_mosi    asynchronous SPI pins from the host
//   spi_miso, spi_miso_oe        data to the host and its output enable
//   spi_din, spi_wr              byte to queue for transmission and its push strobe
//   spi_rd, spi_dout             RX pop strobe and RX head (0 while empty)
//   spi_data_avail               RX FIFO not empty
//   spi_buffer_empty/full        TX FIFO occupancy
//   spi_rx_overflow              sticky: a received byte was dropped
//   spi_tx_underrun              sticky: IDLE_BYTE was sent in place of a missing TX byte
//   spi_clr_err                  clears both sticky flags (a same-clk set wins)

module spi_target_fifo #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       wr_en,
  input  logic [7:0] wr_data,
  input  logic       rd_en,
  output logic [7:0] rd_data,
  output logic       empty,
  output logic       full
);
  localparam int AW = $clog2(DEPTH);

  logic [7:0]    mem_q [DEPTH];
  logic [7:0]    mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          do_push, do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == (AW+1)'(DEPTH));
  assign rd_data = mem_q[rd_ptr_q];

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    do_pop   = rd_en && !empty;
    // A pop in the same clk frees a slot, so a push into a full FIFO still lands.
    do_push  = wr_en && (!full || do_pop);
    if (do_push) begin
      mem_d[wr_ptr_q] = wr_data;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    if (do_push && !do_pop) begin
      count_d = count_q + 1'b1;
    end else if (!do_push && do_pop) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: nothing reads it while the count says empty.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end
endmodule

module spi_target #(
  parameter int         FIFO_DEPTH = 4,
  parameter logic [7:0] IDLE_BYTE  = 8'hFF
) (
  input  logic       clk,
  input  logic       Rst,
  input  logic       spi_sck,
  input  logic       spi_cs,
  input  logic       spi_mosi,
  output logic       spi_miso,
  output logic       spi_miso_oe,
  input  logic [7:0] spi_din,
  input  logic       spi_wr,
  input  logic       spi_rd,
  output logic [7:0] spi_dout,
  output logic       spi_data_avail,
  output logic       spi_buffer_empty,
  output logic       spi_buffer_full,
  output logic       spi_rx_overflow,
  output logic       spi_tx_underrun,
  input  logic       spi_clr_err
);
  typedef enum logic {
    ST_IDLE,
    ST_SHIFT
  } state_t;

  state_t     state_q, state_d;
  logic [3:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] tx_shift_q, tx_shift_d;
  logic [7:0] rx_shift_q, rx_shift_d;
  logic       rx_ovf_q, rx_ovf_d;
  logic       tx_unr_q, tx_unr_d;

  // Two synchroniser stages plus one history stage for edge detection.
  logic sck_s1_q, sck_s1_d, sck_s2_q, sck_s2_d, sck_h_q, sck_h_d;
  logic cs_s1_q, cs_s1_d, cs_s2_q, cs_s2_d, cs_h_q, cs_h_d;
  logic mosi_s1_q, mosi_s1_d, mosi_s2_q, mosi_s2_d;

  logic       sck_rise, sck_fall, cs_rise, cs_fall;
  logic       load, tx_pop, rx_push, underrun_set, overflow_set;
  logic [7:0] rx_byte;
  logic [7:0] tx_head, rx_head;
  logic       tx_empty, tx_full, rx_empty, rx_full;

  assign sck_rise = sck_s2_q && !sck_h_q;
  assign sck_fall = !sck_s2_q && sck_h_q;
  assign cs_rise  = cs_s2_q && !cs_h_q;
  assign cs_fall  = !cs_s2_q && cs_h_q;
  assign rx_byte  = {rx_shift_q[6:0], mosi_s2_q};

  always_comb begin
    sck_s1_d  = spi_sck;
    sck_s2_d  = sck_s1_q;
    sck_h_d   = sck_s2_q;
    cs_s1_d   = spi_cs;
    cs_s2_d   = cs_s1_q;
    cs_h_d    = cs_s2_q;
    mosi_s1_d = spi_mosi;
    mosi_s2_d = mosi_s1_q;

    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    tx_shift_d = tx_shift_q;
    rx_shift_d = rx_shift_q;
    load       = 1'b0;
    tx_pop     = 1'b0;
    rx_push    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (cs_fall) begin
          state_d   = ST_SHIFT;
          bit_cnt_d = '0;
          load      = 1'b1;
        end
      end
      ST_SHIFT: begin
        if (cs_rise) begin
          // Partial RX byte and any loaded TX byte are simply abandoned.
          state_d   = ST_IDLE;
          bit_cnt_d = '0;
        end else if (sck_rise) begin
          rx_shift_d = rx_byte;
          bit_cnt_d  = bit_cnt_q + 4'd1;
          if (bit_cnt_q == 4'd7) begin
            rx_push = 1'b1;
          end
        end else if (sck_fall) begin
          if (bit_cnt_q == 4'd8) begin
            load      = 1'b1;
            bit_cnt_d = '0;
          end else begin
            tx_shift_d = {tx_shift_q[6:0], 1'b0};
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    underrun_set = 1'b0;
    if (load) begin
      if (tx_empty) begin
        tx_shift_d   = IDLE_BYTE;
        underrun_set = 1'b1;
      end else begin
        tx_shift_d = tx_head;
        tx_pop     = 1'b1;
      end
    end

    // A simultaneous software read frees the slot, so only a full FIFO with no read drops.
    overflow_set = rx_push && rx_full && !spi_rd;

    // Set beats clear when both happen in the same clk.
    rx_ovf_d = overflow_set || (rx_ovf_q && !spi_clr_err);
    tx_unr_d = underrun_set || (tx_unr_q && !spi_clr_err);
  end

  always_ff @(posedge clk) begin
    if (Rst) begin
      // cs history resets low so a cs already low at reset release sees no falling edge.
      sck_s1_q   <= 1'b0;
      sck_s2_q   <= 1'b0;
      sck_h_q    <= 1'b0;
      cs_s1_q    <= 1'b0;
      cs_s2_q    <= 1'b0;
      cs_h_q     <= 1'b0;
      mosi_s1_q  <= 1'b0;
      mosi_s2_q  <= 1'b0;
      state_q    <= ST_IDLE;
      bit_cnt_q  <= '0;
      tx_shift_q <= '0;
      rx_shift_q <= '0;
      rx_ovf_q   <= 1'b0;
      tx_unr_q   <= 1'b0;
    end else begin
      sck_s1_q   <= sck_s1_d;
      sck_s2_q   <= sck_s2_d;
      sck_h_q    <= sck_h_d;
      cs_s1_q    <= cs_s1_d;
      cs_s2_q    <= cs_s2_d;
      cs_h_q     <= cs_h_d;
      mosi_s1_q  <= mosi_s1_d;
      mosi_s2_q  <= mosi_s2_d;
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      tx_shift_q <= tx_shift_d;
      rx_shift_q <= rx_shift_d;
      rx_ovf_q   <= rx_ovf_d;
      tx_unr_q   <= tx_unr_d;
    end
  end

  spi_target_fifo #(.DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk     (clk),
    .rst     (Rst),
    .wr_en   (spi_wr),
    .wr_data (spi_din),
    .rd_en   (tx_pop),
    .rd_data (tx_head),
    .empty   (tx_empty),
    .full    (tx_full)
  );

  spi_target_fifo #(.DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk     (clk),
    .rst     (Rst),
    .wr_en   (rx_push),
    .wr_data (rx_byte),
    .rd_en   (spi_rd),
    .rd_data (rx_head),
    .empty   (rx_empty),
    .full    (rx_full)
  );

  assign spi_miso_oe      = (state_q == ST_SHIFT);
  assign spi_miso         = (state_q == ST_SHIFT) ? tx_shift_q[7] : 1'b0;
  assign spi_dout         = rx_empty ? 8'h00 : rx_head;
  assign spi_data_avail   = !rx_empty;
  assign spi_buffer_empty = tx_empty;
  assign spi_buffer_full  = tx_full;
  assign spi_rx_overflow  = rx_ovf_q;
  assign spi_tx_underrun  = tx_unr_q;
endmodule

// File: tb/tb_spi_target.sv
// tb/tb_spi_target.sv - self-checking bench for spi_target
module tb_spi_target;
  logic       clk = 1'b0;
  logic       Rst, spi_sck, spi_cs, spi_mosi, spi_miso, spi_miso_oe;
  logic [7:0] spi_din, spi_dout;
  logic       spi_wr, spi_rd, spi_data_avail, spi_buffer_empty, spi_buffer_full;
  logic       spi_rx_overflow, spi_tx_underrun, spi_clr_err;

  always #5 clk = ~clk;

  spi_target #(.FIFO_DEPTH(4), .IDLE_BYTE(8'hFF)) dut (
    .clk(clk), .Rst(Rst), .spi_sck(spi_sck), .spi_cs(spi_cs), .spi_mosi(spi_mosi),
    .spi_miso(spi_miso), .spi_miso_oe(spi_miso_oe), .spi_din(spi_din), .spi_wr(spi_wr),
    .spi_rd(spi_rd), .spi_dout(spi_dout), .spi_data_avail(spi_data_avail),
    .spi_buffer_empty(spi_buffer_empty), .spi_buffer_full(spi_buffer_full),
    .spi_rx_overflow(spi_rx_overflow), .spi_tx_underrun(spi_tx_underrun),
    .spi_clr_err(spi_clr_err)
  );

  int checks = 0;
  int errors = 0;

  logic [7:0] host_mosi [8];
  logic [7:0] host_miso [8];
  logic       avail_n2, avail_n3, first_n2, first_n3;

  typedef struct {
    int         n_push;
    logic [7:0] push [5];
    int         n_xfer;
    logic [7:0] mosi [5];
    logic [7:0] miso [5];
    int         n_rx;
    logic       ovf;
    logic       unr;
    int         tx_left;
  } vec_t;

  vec_t vt [5];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    Rst = 1'b1;
    repeat (2) @(negedge clk);
    Rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic wr_byte(input logic [7:0] b);
    spi_din = b;
    spi_wr  = 1'b1;
    @(negedge clk);
    spi_wr  = 1'b0;
  endtask

  task automatic rd_check(input string name, input logic [7:0] exp);
    check(name, spi_dout, exp);
    spi_rd = 1'b1;
    @(negedge clk);
    spi_rd = 1'b0;
  endtask

  task automatic pulse_clr();
    spi_clr_err = 1'b1;
    @(negedge clk);
    spi_clr_err = 1'b0;
  endtask

  // One mode-0 bit at 8 clk per sck period; MISO is sampled just before the rising edge.
  task automatic host_bit(input logic mosi_bit, input logic rd_pulse, output logic miso_bit);
    spi_mosi = mosi_bit;
    repeat (4) @(negedge clk);
    miso_bit = spi_miso;
    spi_sck  = 1'b1;
    repeat (2) @(negedge clk);
    avail_n2 = spi_data_avail;
    if (rd_pulse) spi_rd = 1'b1;
    @(negedge clk);
    avail_n3 = spi_data_avail;
    spi_rd = 1'b0;
    @(negedge clk);
    spi_sck = 1'b0;
  endtask

  // abort_bits>0 clocks only that many bits of the first byte before deselecting.
  task automatic host_xfer(input int n, input int abort_bits, input int rd_byte);
    logic [7:0] m;
    logic       bit_v;
    int         nb;
    spi_cs = 1'b0;
    repeat (4) @(negedge clk);
    nb = (abort_bits > 0) ? abort_bits : 8;
    for (int b = 0; b < n; b++) begin
      m = 8'h00;
      for (int k = 0; k < nb; k++) begin
        host_bit(host_mosi[b][7-k], (rd_byte == b + 1) && (k == 7), bit_v);
        m[7-k] = bit_v;
        if (b == 0 && k == 7) begin
          first_n2 = avail_n2;
          first_n3 = avail_n3;
        end
      end
      host_miso[b] = m;
    end
    repeat (4) @(negedge clk);
    spi_cs = 1'b1;
    repeat (6) @(negedge clk);
  endtask

  // Reference model: queues plus the rule that a window of n full bytes performs n+1 loads.
  logic [7:0] txq[$], rxq[$], exp_miso[$];
  logic       m_ovf, m_unr;

  task automatic model_window(input int n);
    exp_miso.delete();
    for (int l = 0; l <= n; l++) begin
      logic [7:0] v;
      if (txq.size() > 0) v = txq.pop_front();
      else begin v = 8'hFF; m_unr = 1'b1; end
      if (l < n) exp_miso.push_back(v);
    end
    for (int b = 0; b < n; b++) begin
      if (rxq.size() < 4) rxq.push_back(host_mosi[b]);
      else m_ovf = 1'b1;
    end
  endtask

  initial begin
    Rst = 1'b1; spi_sck = 1'b0; spi_cs = 1'b1; spi_mosi = 1'b0; spi_din = 8'h00;
    spi_wr = 1'b0; spi_rd = 1'b0; spi_clr_err = 1'b0;

    vt[0].n_push = 1; vt[0].push = '{8'hA5, 8'h00, 8'h00, 8'h00, 8'h00};
    vt[0].n_xfer = 1; vt[0].mosi = '{8'h3C, 8'h00, 8'h00, 8'h00, 8'h00};
    vt[0].miso = '{8'hA5, 8'h00, 8'h00, 8'h00, 8'h00};
    vt[0].n_rx = 1; vt[0].ovf = 1'b0; vt[0].unr = 1'b1; vt[0].tx_left = 0;

    vt[1].n_push = 2; vt[1].push = '{8'h11, 8'h22, 8'h00, 8'h00, 8'h00};
    vt[1].n_xfer = 3; vt[1].mosi = '{8'hC1, 8'hC2, 8'hC3, 8'h00, 8'h00};
    vt[1].miso = '{8'h11, 8'h22, 8'hFF, 8'h00, 8'h00};
    vt[1].n_rx = 3; vt[1].ovf = 1'b0; vt[1].unr = 1'b1; vt[1].tx_left = 0;

    vt[2].n_push = 0; vt[2].push = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    vt[2].n_xfer = 5; vt[2].mosi = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
    vt[2].miso = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
    vt[2].n_rx = 4; vt[2].ovf = 1'b1; vt[2].unr = 1'b1; vt[2].tx_left = 0;

    vt[3].n_push = 5; vt[3].push = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
    vt[3].n_xfer = 4; vt[3].mosi = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'h00};
    vt[3].miso = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h00};
    vt[3].n_rx = 4; vt[3].ovf = 1'b0; vt[3].unr = 1'b1; vt[3].tx_left = 0;

    vt[4].n_push = 4; vt[4].push = '{8'hF1, 8'hF2, 8'hF3, 8'hF4, 8'h00};
    vt[4].n_xfer = 2; vt[4].mosi = '{8'h5A, 8'hA5, 8'h00, 8'h00, 8'h00};
    vt[4].miso = '{8'hF1, 8'hF2, 8'h00, 8'h00, 8'h00};
    vt[4].n_rx = 2; vt[4].ovf = 1'b0; vt[4].unr = 1'b0; vt[4].tx_left = 1;

    // Reset state
    do_reset();
    check("rst_miso", spi_miso, 0);
    check("rst_oe", spi_miso_oe, 0);
    check("rst_dout", spi_dout, 0);
    check("rst_avail", spi_data_avail, 0);
    check("rst_empty", spi_buffer_empty, 1);
    check("rst_full", spi_buffer_full, 0);
    check("rst_ovf", spi_rx_overflow, 0);
    check("rst_unr", spi_tx_underrun, 0);

    // Table-driven transfers
    for (int r = 0; r < 5; r++) begin
      do_reset();
      for (int p = 0; p < vt[r].n_push; p++) begin
        wr_byte(vt[r].push[p]);
        check($sformatf("v%0d_full_p%0d", r, p), spi_buffer_full, (p >= 3) ? 1 : 0);
      end
      for (int b = 0; b < 5; b++) host_mosi[b] = vt[r].mosi[b];
      host_xfer(vt[r].n_xfer, 0, 0);
      for (int b = 0; b < vt[r].n_xfer; b++)
        check($sformatf("v%0d_miso%0d", r, b), host_miso[b], vt[r].miso[b]);
      check($sformatf("v%0d_avail_before", r), first_n2, 0);
      check($sformatf("v%0d_avail_after", r), first_n3, 1);
      check($sformatf("v%0d_oe_idle", r), spi_miso_oe, 0);
      check($sformatf("v%0d_ovf", r), spi_rx_overflow, vt[r].ovf);
      check($sformatf("v%0d_unr", r), spi_tx_underrun, vt[r].unr);
      check($sformatf("v%0d_txempty", r), spi_buffer_empty, (vt[r].tx_left == 0) ? 1 : 0);
      for (int k = 0; k < vt[r].n_rx; k++) begin
        check($sformatf("v%0d_avail%0d", r, k), spi_data_avail, 1);
        rd_check($sformatf("v%0d_rx%0d", r, k), vt[r].mosi[k]);
      end
      check($sformatf("v%0d_drained", r), spi_data_avail, 0);
      pulse_clr();
      check($sformatf("v%0d_clr_unr", r), spi_tx_underrun, 0);
      check($sformatf("v%0d_clr_ovf", r), spi_rx_overflow, 0);
    end

    // spi_rd on the same clk as the 5th push: no overflow, 02..05 remain
    do_reset();
    for (int b = 0; b < 5; b++) host_mosi[b] = 8'(b + 1);
    host_xfer(5, 0, 5);
    check("rdpush_ovf", spi_rx_overflow, 0);
    for (int k = 0; k < 4; k++) rd_check($sformatf("rdpush_rx%0d", k), 8'(k + 2));
    check("rdpush_drained", spi_data_avail, 0);

    // Aborted byte after 5 bits
    do_reset();
    wr_byte(8'h5A);
    host_mosi[0] = 8'hF0;
    host_xfer(1, 5, 0);
    check("abort_avail", spi_data_avail, 0);
    check("abort_oe", spi_miso_oe, 0);
    check("abort_consumed", spi_buffer_empty, 1);
    check("abort_unr", spi_tx_underrun, 0);
    host_mosi[0] = 8'h96;
    host_xfer(1, 0, 0);
    check("abort_next_miso", host_miso[0], 8'hFF);
    rd_check("abort_next_rx", 8'h96);
    check("abort_next_drained", spi_data_avail, 0);

    // Reset for one clk mid-transfer with cs held low
    do_reset();
    wr_byte(8'h77);
    spi_cs = 1'b0;
    repeat (4) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      logic bv;
      host_bit(1'b1, 1'b0, bv);
    end
    Rst = 1'b1;
    @(negedge clk);
    Rst = 1'b0;
    check("midrst_oe", spi_miso_oe, 0);
    check("midrst_miso", spi_miso, 0);
    check("midrst_empty", spi_buffer_empty, 1);
    check("midrst_avail", spi_data_avail, 0);
    check("midrst_unr", spi_tx_underrun, 0);
    for (int k = 0; k < 8; k++) begin
      logic bv;
      host_bit(1'b0, 1'b0, bv);
      check($sformatf("midrst_quiet_oe%0d", k), spi_miso_oe, 0);
    end
    check("midrst_quiet_avail", spi_data_avail, 0);
    spi_cs = 1'b1;
    repeat (6) @(negedge clk);
    host_mosi[0] = 8'h5E;
    host_xfer(1, 0, 0);
    check("midrst_next_miso", host_miso[0], 8'hFF);
    check("midrst_next_unr", spi_tx_underrun, 1);
    rd_check("midrst_next_rx", 8'h5E);

    // Randomised windows against the queue model
    do_reset();
    txq.delete(); rxq.delete(); m_ovf = 1'b0; m_unr = 1'b0;
    for (int it = 0; it < 10; it++) begin
      int np, n, nr;
      np = $urandom_range(0, 5);
      for (int p = 0; p < np; p++) begin
        logic [7:0] v;
        v = 8'($urandom);
        wr_byte(v);
        if (txq.size() < 4) txq.push_back(v);
      end
      check($sformatf("r%0d_full", it), spi_buffer_full, (txq.size() == 4) ? 1 : 0);
      n = $urandom_range(1, 5);
      for (int b = 0; b < n; b++) host_mosi[b] = 8'($urandom);
      model_window(n);
      host_xfer(n, 0, 0);
      for (int b = 0; b < n; b++)
        check($sformatf("r%0d_miso%0d", it, b), host_miso[b], exp_miso[b]);
      check($sformatf("r%0d_ovf", it), spi_rx_overflow, m_ovf);
      check($sformatf("r%0d_unr", it), spi_tx_underrun, m_unr);
      check($sformatf("r%0d_txempty", it), spi_buffer_empty, (txq.size() == 0) ? 1 : 0);
      nr = $urandom_range(0, rxq.size() + 1);
      for (int k = 0; k < nr; k++) begin
        if (rxq.size() > 0) rd_check($sformatf("r%0d_rx%0d", it, k), rxq.pop_front());
        else begin
          spi_rd = 1'b1;
          @(negedge clk);
          spi_rd = 1'b0;
          check($sformatf("r%0d_empty_rd", it), spi_data_avail, 0);
        end
      end
      check($sformatf("r%0d_avail", it), spi_data_avail, (rxq.size() > 0) ? 1 : 0);
      if ($urandom_range(0, 1) == 1) begin
        pulse_clr();
        m_ovf = 1'b0;
        m_unr = 1'b0;
        check($sformatf("r%0d_clr", it), {spi_rx_overflow, spi_tx_underrun}, 0);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
